// File: rtl/adder_tree_loader.sv
// adder_tree_loader: packs a serial LEN-bit word stream into NUM-word frames
// held in two ping-pong banks, presented as the flat vector adder_tree consumes.

// One frame bank: word storage, full flag and latched word count.
module adder_tree_loader_bank #(
  parameter int NUM   = 4096,
  parameter int LEN   = 16,
  parameter int CNT_W = $clog2(NUM+1),
  parameter int IDX_W = $clog2(NUM)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [LEN-1:0]       wr_data,
  input  logic                 close,
  input  logic [CNT_W-1:0]     close_cnt,
  input  logic                 rel,
  output logic [NUM*LEN-1:0]   data,
  output logic                 full,
  output logic [CNT_W-1:0]     count
);
  logic [NUM-1:0][LEN-1:0] data_q, data_d;
  logic                    full_q, full_d;
  logic [CNT_W-1:0]        count_q, count_d;

  // Release zeroes the bank so unwritten slots of the next frame read as zero.
  // Writes and release never target the same bank in one cycle: a bank is
  // only written while not full and only released while full.
  always_comb begin
    data_d  = data_q;
    full_d  = full_q;
    count_d = count_q;
    if (rel) begin
      data_d  = '0;
      full_d  = 1'b0;
      count_d = '0;
    end else if (wr_en) begin
      data_d[wr_idx] = wr_data;
      if (close) begin
        full_d  = 1'b1;
        count_d = close_cnt;
      end
    end
  end

  // Bank state register with synchronous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      full_q  <= 1'b0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      full_q  <= full_d;
      count_q <= count_d;
    end
  end

  assign data  = data_q;
  assign full  = full_q;
  assign count = count_q;
endmodule

module adder_tree_loader #(
  parameter int NUM   = 4096,
  parameter int LEN   = 16,
  parameter int CNT_W = $clog2(NUM+1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LEN-1:0]       in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM*LEN-1:0]   out_vec,
  output logic [CNT_W-1:0]     out_count
);
  localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;

  logic [1:0][NUM*LEN-1:0] bank_data;
  logic [1:0]              bank_full;
  logic [1:0][CNT_W-1:0]   bank_count;
  logic [1:0]              bank_wr, bank_rel;

  logic accept, close, rel;

  assign in_ready = rst_n && !bank_full[wr_sel_q];
  assign accept   = in_valid && in_ready;
  assign close    = accept && (in_last || (cnt_q == CNT_W'(NUM-1)));
  assign out_valid = bank_full[rd_sel_q];
  assign rel       = out_valid && out_ready;
  assign out_vec   = bank_data[rd_sel_q];
  assign out_count = bank_count[rd_sel_q];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_wr[b]  = accept && (wr_sel_q == 1'(b));
    assign bank_rel[b] = rel && (rd_sel_q == 1'(b));
    adder_tree_loader_bank #(
      .NUM(NUM), .LEN(LEN), .CNT_W(CNT_W), .IDX_W(IDX_W)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (bank_wr[b]),
      .wr_idx    (cnt_q[IDX_W-1:0]),
      .wr_data   (in_data),
      .close     (close),
      .close_cnt (cnt_q + CNT_W'(1)),
      .rel       (bank_rel[b]),
      .data      (bank_data[b]),
      .full      (bank_full[b]),
      .count     (bank_count[b])
    );
  end

  // Word counter and bank pointers: close flips the write bank, release the read bank.
  always_comb begin
    cnt_d    = cnt_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    if (accept) cnt_d = close ? '0 : cnt_q + CNT_W'(1);
    if (close)  wr_sel_d = ~wr_sel_q;
    if (rel)    rd_sel_d = ~rd_sel_q;
  end

  // Pointer/counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
    end
  end
endmodule

// File: tb/tb_adder_tree_loader.sv
// Bench for adder_tree_loader (NUM=4, LEN=8) with a frame scoreboard.
module tb_adder_tree_loader;
  localparam int NUM = 4;
  localparam int LEN = 8;
  localparam int CNT_W = $clog2(NUM+1);

  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, in_last = 0;
  logic [LEN-1:0] in_data = '0;
  logic out_valid, out_ready = 0;
  logic [NUM*LEN-1:0] out_vec;
  logic [CNT_W-1:0] out_count;

  typedef struct {
    logic [NUM*LEN-1:0] vec;
    int cnt;
    int sum;
  } frame_t;
  frame_t sb[$];

  int checks = 0, errors = 0;

  adder_tree_loader #(.NUM(NUM), .LEN(LEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_vec(out_vec), .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic push_frame(input logic [NUM*LEN-1:0] vec, input int cnt);
    frame_t f;
    f.vec = vec; f.cnt = cnt; f.sum = 0;
    for (int k = 0; k < NUM; k++) f.sum += int'(vec[k*LEN +: LEN]);
    sb.push_back(f);
  endtask

  // Scoreboard: every frame taken by the consumer is popped and compared,
  // including the adder_tree reference sum of its words.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      frame_t f;
      int s;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got vec=%h cnt=%0d", out_vec, out_count);
      end else begin
        f = sb.pop_front();
        s = 0;
        for (int k = 0; k < NUM; k++) s += int'(out_vec[k*LEN +: LEN]);
        if (out_vec !== f.vec || out_count !== CNT_W'(f.cnt) || s != f.sum) begin
          errors++;
          $display("FAIL sb_frame got vec=%h cnt=%0d sum=%0d want vec=%h cnt=%0d sum=%0d",
                   out_vec, out_count, s, f.vec, f.cnt, f.sum);
        end
      end
    end
  end

  task automatic send(input logic [LEN-1:0] d, input logic last);
    logic acc;
    acc = 0;
    in_valid = 1; in_data = d; in_last = last;
    for (int n = 0; n < 64 && !acc; n++) begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 0; in_last = 0;
    checks++;
    if (!acc) begin errors++; $display("FAIL send_timeout word=%h never accepted", d); end
  endtask

  task automatic drain();
    int n;
    out_ready = 1;
    for (n = 0; n < 100 && sb.size() != 0; n++) begin @(posedge clk); #1; end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL drain_timeout pending=%0d want 0", sb.size()); end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 0 || out_vec !== '0 || out_count !== '0 || in_ready !== 0) begin
      errors++;
      $display("FAIL reset_state got v=%b vec=%h cnt=%0d rdy=%b want 0", out_valid, out_vec, out_count, in_ready);
    end
    rst_n = 1;
    #1;
    checks++;
    if (in_ready !== 1) begin errors++; $display("FAIL reset_release in_ready=%b want 1", in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1;
    push_frame(32'h04030201, 4);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    checks++;
    if (out_valid !== 1 || out_vec !== 32'h04030201 || out_count !== 3'd4) begin
      errors++;
      $display("FAIL basic_latency got v=%b vec=%h cnt=%0d want v=1 vec=04030201 cnt=4", out_valid, out_vec, out_count);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 0) begin errors++; $display("FAIL basic_release out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_last();
    push_frame(32'h0000BBAA, 2);
    send(8'hAA, 0); send(8'hBB, 1);
    push_frame(32'h44332211, 4);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    push_frame(32'h00000055, 1);
    send(8'h55, 1);
    drain();
  endtask

  task automatic test_stall();
    out_ready = 0;
    push_frame(32'h04030201, 4);
    push_frame(32'h08070605, 4);
    for (int i = 1; i <= 8; i++) send(8'(i), 0);
    checks++;
    if (in_ready !== 0 || out_vec !== 32'h04030201) begin
      errors++;
      $display("FAIL stall_full got rdy=%b vec=%h want rdy=0 vec=04030201", in_ready, out_vec);
    end
    in_valid = 1; in_data = 8'h09;
    @(negedge clk);
    checks++;
    if (in_ready !== 0) begin errors++; $display("FAIL stall_9th in_ready=%b want 0", in_ready); end
    @(posedge clk); #1;
    checks++;
    if (out_vec !== 32'h04030201 || out_count !== 3'd4) begin
      errors++;
      $display("FAIL stall_hold got vec=%h cnt=%0d want 04030201 4", out_vec, out_count);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    checks++;
    if (out_vec !== 32'h08070605 || in_ready !== 1 || out_valid !== 1) begin
      errors++;
      $display("FAIL stall_next got vec=%h rdy=%b v=%b want 08070605 1 1", out_vec, in_ready, out_valid);
    end
    @(posedge clk); #1;
    in_valid = 0;
    push_frame(32'h0C0B0A09, 4);
    send(8'h0A, 0); send(8'h0B, 0); send(8'h0C, 0);
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 0;
    push_frame(32'h14131211, 4);
    push_frame(32'h18171615, 4);
    for (int i = 0; i < 8; i++) send(8'h11 + 8'(i), 0);
    in_valid = 1; in_data = 8'h21; out_ready = 1;
    @(negedge clk);
    checks++;
    if (in_ready !== 0) begin errors++; $display("FAIL b2b_same_cycle in_ready=%b want 0", in_ready); end
    @(posedge clk); #1;
    out_ready = 0;
    checks++;
    if (out_valid !== 1 || in_ready !== 1 || out_vec !== 32'h18171615) begin
      errors++;
      $display("FAIL b2b_next got v=%b rdy=%b vec=%h want 1 1 18171615", out_valid, in_ready, out_vec);
    end
    @(posedge clk); #1;
    in_valid = 0;
    push_frame(32'h24232221, 4);
    send(8'h22, 0); send(8'h23, 0); send(8'h24, 0);
    drain();
  endtask

  task automatic test_mid_reset();
    out_ready = 1;
    send(8'h0A, 0); send(8'h0B, 0);
    rst_n = 0;
    @(negedge clk);
    checks++;
    if (in_ready !== 0) begin errors++; $display("FAIL rst_ready in_ready=%b want 0", in_ready); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 0 || out_vec !== '0 || out_count !== '0) begin
      errors++;
      $display("FAIL rst_clear got v=%b vec=%h cnt=%0d want 0", out_valid, out_vec, out_count);
    end
    rst_n = 1;
    push_frame(32'h04030201, 4);
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
    drain();
  endtask

  task automatic test_chain_sum();
    out_ready = 1;
    push_frame(32'h06050302, 4);
    send(8'h02, 0); send(8'h03, 0); send(8'h05, 0); send(8'h06, 0);
    push_frame(32'h09070301, 4);
    send(8'h01, 0); send(8'h03, 0); send(8'h07, 0); send(8'h09, 0);
    push_frame(32'h00FFFFFF, 3);
    send(8'hFF, 0); send(8'hFF, 0); send(8'hFF, 1);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_last();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    test_chain_sum();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0 || out_valid !== 0) begin
      errors++;
      $display("FAIL end_idle pending=%0d v=%b want 0 0", sb.size(), out_valid);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
